// File: rtl/hureader_pkg.sv
// Shared definitions for the HuCard reader PIO master: reader register map,
// controller and bus-cycle state encodings.
package hureader_pkg;

   localparam int ADDR_W = 21;
   localparam int LEN_W  = 22;

   localparam logic [2:0] REG_ADL     = 3'd0;
   localparam logic [2:0] REG_ADM     = 3'd1;
   localparam logic [2:0] REG_ADH     = 3'd2;
   localparam logic [2:0] REG_DATA    = 3'd3;
   localparam logic [2:0] REG_AUTOINC = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADH,
      WR_ADM,
      WR_ADL,
      RD_BYTE,
      WAIT_OUT,
      FINISH
   } state_t;

   typedef enum logic [1:0] {
      CYC_IDLE,
      CYC_SETUP,
      CYC_STROBE,
      CYC_HOLD
   } cyc_state_t;

endpackage

// File: rtl/hureader_pio_cycle.sv
// One timed reader bus cycle: setup with CS low, strobe, hold, then CS high.
// All bus outputs are registered so they change cleanly on clock edges.
module hureader_pio_cycle
   import hureader_pkg::*;
#(
   parameter int T_SETUP  = 2,
   parameter int T_STROBE = 4,
   parameter int T_HOLD   = 2
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       wr,
   input  logic [2:0] reg_sel,
   input  logic [7:0] wdata,
   output logic       done,
   output logic [7:0] rdata,
   output logic       pexp_cs_n,
   output logic       prd_n,
   output logic       pwr_n,
   output logic [2:0] pa,
   output logic [7:0] pd_out,
   output logic       pd_oe,
   input  logic [7:0] pd_in
);

   localparam int CNT_W = 8;

   cyc_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             wr_q, wr_nx;
   logic [2:0]       pa_nx;
   logic [7:0]       pd_out_nx;
   logic             load_rd;

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      wr_nx     = wr_q;
      pa_nx     = pa;
      pd_out_nx = pd_out;
      load_rd   = 1'b0;
      unique case (state)
         CYC_IDLE: begin
            if (start) begin
               state_nx  = CYC_SETUP;
               cnt_nx    = CNT_W'(T_SETUP - 1);
               wr_nx     = wr;
               pa_nx     = reg_sel;
               pd_out_nx = wr ? wdata : 8'h00;
            end
         end
         CYC_SETUP: begin
            if (cnt == '0) begin
               state_nx = CYC_STROBE;
               cnt_nx   = CNT_W'(T_STROBE - 1);
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         CYC_STROBE: begin
            // pd_in is captured on the edge that ends the last strobe-low clock
            if (cnt == '0) begin
               state_nx = CYC_HOLD;
               cnt_nx   = CNT_W'(T_HOLD - 1);
               load_rd  = ~wr_q;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         CYC_HOLD: begin
            if (cnt == '0) begin
               state_nx = CYC_IDLE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         default: state_nx = CYC_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= CYC_IDLE;
         cnt       <= '0;
         wr_q      <= 1'b0;
         pa        <= 3'd0;
         pd_out    <= 8'h00;
         pd_oe     <= 1'b0;
         pexp_cs_n <= 1'b1;
         prd_n     <= 1'b1;
         pwr_n     <= 1'b1;
         rdata     <= 8'h00;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         wr_q      <= wr_nx;
         pa        <= pa_nx;
         pd_out    <= pd_out_nx;
         pexp_cs_n <= (state_nx == CYC_IDLE);
         pd_oe     <= (state_nx != CYC_IDLE) && wr_nx;
         prd_n     <= ~((state_nx == CYC_STROBE) && !wr_nx);
         pwr_n     <= ~((state_nx == CYC_STROBE) && wr_nx);
         done      <= (state == CYC_HOLD) && (state_nx == CYC_IDLE);
         if (load_rd) begin
            rdata <= pd_in;
         end
      end
   end

endmodule

// File: rtl/hureader_pio_master.sv
// HuCard reader PIO master: sets the reader address, streams bytes out with a
// valid/ready handshake. Define HUREADER_AUTOINC_EN to use the auto-increment port.
//
//  state    | meaning
//  IDLE     | waiting for cmd_start
//  WR_ADH   | writing address bits 20:16
//  WR_ADM   | writing address bits 15:8
//  WR_ADL   | writing address bits 7:0
//  RD_BYTE  | reading one card byte
//  WAIT_OUT | CS high until the read byte is accepted, then pick next cycle
//  FINISH   | done pulse, back to IDLE
module hureader_pio_master
   import hureader_pkg::*;
#(
   parameter int T_SETUP  = 2,
   parameter int T_STROBE = 4,
   parameter int T_HOLD   = 2
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_abort,
   output logic              busy,
   output logic              done,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              pexp_cs_n,
   output logic              prd_n,
   output logic              pwr_n,
   output logic [2:0]        pa,
   output logic [7:0]        pd_out,
   output logic              pd_oe,
   input  logic [7:0]        pd_in
);

`ifdef HUREADER_AUTOINC_EN
   localparam logic AUTOINC_EN = 1'b1;
`else
   localparam logic AUTOINC_EN = 1'b0;
`endif

   state_t            state, state_nx, follow;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic              launched;
   logic              is_bus;
   logic              rd_load;
   logic              cyc_start, cyc_wr, cyc_done;
   logic [2:0]        cyc_reg;
   logic [7:0]        cyc_wdata, cyc_rdata;

   hureader_pio_cycle #(
      .T_SETUP  (T_SETUP),
      .T_STROBE (T_STROBE),
      .T_HOLD   (T_HOLD)
   ) u_cycle (
      .clock     (clock),
      .reset     (reset),
      .start     (cyc_start),
      .wr        (cyc_wr),
      .reg_sel   (cyc_reg),
      .wdata     (cyc_wdata),
      .done      (cyc_done),
      .rdata     (cyc_rdata),
      .pexp_cs_n (pexp_cs_n),
      .prd_n     (prd_n),
      .pwr_n     (pwr_n),
      .pa        (pa),
      .pd_out    (pd_out),
      .pd_oe     (pd_oe),
      .pd_in     (pd_in)
   );

   always_comb begin
      state_nx  = state;
      follow    = state;
      is_bus    = 1'b0;
      cyc_start = 1'b0;
      cyc_wr    = 1'b1;
      cyc_reg   = REG_ADL;
      cyc_wdata = 8'h00;
      unique case (state)
         IDLE: begin
            if (cmd_start) begin
               state_nx = (cmd_len == '0) ? FINISH : WR_ADH;
            end
         end
         WR_ADH: begin
            is_bus    = 1'b1;
            cyc_reg   = REG_ADH;
            cyc_wdata = {3'b000, addr[20:16]};
            follow    = WR_ADM;
         end
         WR_ADM: begin
            is_bus    = 1'b1;
            cyc_reg   = REG_ADM;
            cyc_wdata = addr[15:8];
            follow    = WR_ADL;
         end
         WR_ADL: begin
            is_bus    = 1'b1;
            cyc_reg   = REG_ADL;
            cyc_wdata = addr[7:0];
            follow    = RD_BYTE;
         end
         RD_BYTE: begin
            is_bus  = 1'b1;
            cyc_wr  = 1'b0;
            cyc_reg = AUTOINC_EN ? REG_AUTOINC : REG_DATA;
            follow  = WAIT_OUT;
         end
         WAIT_OUT: begin
            // addr already points at the next byte here
            if (cmd_abort) begin
               state_nx = FINISH;
            end else if (!rd_valid || rd_ready) begin
               if (remaining == '0) begin
                  state_nx = FINISH;
               end else if (addr[15:0] == 16'h0000) begin
                  state_nx = WR_ADH;
               end else if (addr[7:0] == 8'h00) begin
                  state_nx = WR_ADM;
               end else if (AUTOINC_EN) begin
                  state_nx = RD_BYTE;
               end else begin
                  state_nx = WR_ADL;
               end
            end
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // an abort seen before launch skips the cycle; once launched it runs to the end
      if (is_bus) begin
         if (!launched) begin
            if (cmd_abort) begin
               state_nx = FINISH;
            end else begin
               cyc_start = 1'b1;
            end
         end else if (cyc_done) begin
            state_nx = cmd_abort ? FINISH : follow;
         end
      end
   end

   assign rd_load = (state == RD_BYTE) && cyc_done && !cmd_abort;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         launched  <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         rd_data   <= 8'h00;
         rd_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
         done  <= (state_nx == FINISH);

         if (cyc_done) begin
            launched <= 1'b0;
         end else if (cyc_start) begin
            launched <= 1'b1;
         end

         if (state == IDLE && cmd_start) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
         end else if (state == RD_BYTE && cyc_done) begin
            addr      <= addr + 21'd1;
            remaining <= remaining - 22'd1;
         end

         if (state == FINISH) begin
            rd_valid <= 1'b0;
         end else if (rd_load) begin
            rd_valid <= 1'b1;
            rd_data  <= cyc_rdata;
         end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hureader_pio_master.sv
// Directed bench for hureader_pio_master; expectations follow HUREADER_AUTOINC_EN.
module tb_hureader_pio_master;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_start = 1'b0;
   logic [20:0] cmd_addr = '0;
   logic [21:0] cmd_len = '0;
   logic        cmd_abort = 1'b0;
   logic        rd_ready = 1'b1;
   logic        busy, done, rd_valid, pexp_cs_n, prd_n, pwr_n, pd_oe;
   logic [7:0]  rd_data, pd_out, pd_in;
   logic [2:0]  pa;

`ifdef HUREADER_AUTOINC_EN
   localparam logic [2:0] RD_PA = 3'd7;
`else
   localparam logic [2:0] RD_PA = 3'd3;
`endif

   logic [7:0]  card [0:31];
   int          rd_idx = 0;
   int          done_cnt = 0;
   int          cs_total = 0;
   int          overlap = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [27:0] bus_q[$];
   logic [27:0] exp_q[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_rx[$];

   hureader_pio_master dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_start (cmd_start),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_abort (cmd_abort),
      .busy      (busy),
      .done      (done),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .pexp_cs_n (pexp_cs_n),
      .prd_n     (prd_n),
      .pwr_n     (pwr_n),
      .pa        (pa),
      .pd_out    (pd_out),
      .pd_oe     (pd_oe),
      .pd_in     (pd_in)
   );

   always #5 clock = ~clock;

   assign pd_in = card[rd_idx[4:0]];

   // bus monitor: one record per CS-low window {cs clocks, strobe clocks, write+oe, pa, write data}
   int         cs_clks = 0;
   int         strb_clks = 0;
   logic       in_cyc = 1'b0;
   logic       saw_wr = 1'b0;
   logic [2:0] m_pa = '0;
   logic [7:0] m_data = '0;
   logic       prev_prd = 1'b1;

   always @(negedge clock) begin
      if (!pexp_cs_n) begin
         in_cyc = 1'b1;
         cs_clks++;
         cs_total++;
         m_pa = pa;
         if (!prd_n || !pwr_n) strb_clks++;
         if (!pwr_n) begin
            saw_wr = pd_oe;
            m_data = pd_out;
         end
      end else if (in_cyc) begin
         bus_q.push_back({cs_clks[7:0], strb_clks[7:0], saw_wr, m_pa, m_data});
         in_cyc    = 1'b0;
         cs_clks   = 0;
         strb_clks = 0;
         saw_wr    = 1'b0;
         m_data    = 8'h00;
      end
      if (!prd_n && !pwr_n) overlap++;
      if (!prev_prd && prd_n) rd_idx++;
      prev_prd = prd_n;
      if (rd_valid && rd_ready) rx_q.push_back(rd_data);
      if (done) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] wc(input logic [2:0] a, input logic [7:0] d);
      return {8'd8, 8'd4, 1'b1, a, d};
   endfunction

   function automatic logic [27:0] rc();
      return {8'd8, 8'd4, 1'b0, RD_PA, 8'h00};
   endfunction

   task automatic check_bus(input string tag, input int base);
      check($sformatf("%s cycles", tag), bus_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < bus_q.size())
            check($sformatf("%s cyc%0d", tag, i), {4'h0, bus_q[base+i]}, {4'h0, exp_q[i]});
      end
      exp_q.delete();
   endtask

   task automatic check_rx(input string tag, input int base);
      check($sformatf("%s bytes", tag), rx_q.size() - base, exp_rx.size());
      for (int i = 0; i < exp_rx.size(); i++) begin
         if (base + i < rx_q.size())
            check($sformatf("%s byte%0d", tag, i), {24'h0, rx_q[base+i]}, {24'h0, exp_rx[i]});
      end
      exp_rx.delete();
   endtask

   task automatic start_cmd(input logic [20:0] a, input logic [21:0] l);
      cmd_addr  = a;
      cmd_len   = l;
      cmd_start = 1'b1;
      tick(1);
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0, input int budget);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick(1);
         n++;
      end
      tick(3);
      check($sformatf("%s done pulses", tag), done_cnt - d0, 1);
      check($sformatf("%s busy after", tag), {31'h0, busy}, 32'h0);
   endtask

   int d0, bb, rb, snap, n;

   initial begin
      card[0] = 8'hA5;
      card[1] = 8'h5A;
      card[2] = 8'hC3;
      for (int i = 3; i < 32; i++) card[i] = 8'h30 + 8'(i);

      tick(2);
      check("reset outputs",
            {18'h0, pexp_cs_n, prd_n, pwr_n, pd_oe, pa, pd_out, rd_data, rd_valid, busy, done},
            {18'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
      reset = 1'b0;
      tick(2);

      // three bytes from 0x000010
      d0 = done_cnt; bb = bus_q.size(); rb = rx_q.size();
      start_cmd(21'h000010, 22'd3);
      check("s1 busy", {31'h0, busy}, 32'h1);
      wait_done("s1", d0, 400);
      exp_q.push_back(wc(3'd2, 8'h00));
      exp_q.push_back(wc(3'd1, 8'h00));
      exp_q.push_back(wc(3'd0, 8'h10));
      exp_q.push_back(rc());
`ifndef HUREADER_AUTOINC_EN
      exp_q.push_back(wc(3'd0, 8'h11));
`endif
      exp_q.push_back(rc());
`ifndef HUREADER_AUTOINC_EN
      exp_q.push_back(wc(3'd0, 8'h12));
`endif
      exp_q.push_back(rc());
      check_bus("s1", bb);
      exp_rx.push_back(8'hA5);
      exp_rx.push_back(8'h5A);
      exp_rx.push_back(8'hC3);
      check_rx("s1", rb);

      // page crossing from 0x0001FE
      d0 = done_cnt; bb = bus_q.size(); rb = rx_q.size();
      start_cmd(21'h0001FE, 22'd4);
      wait_done("s2", d0, 500);
      exp_q.push_back(wc(3'd2, 8'h00));
      exp_q.push_back(wc(3'd1, 8'h01));
      exp_q.push_back(wc(3'd0, 8'hFE));
      exp_q.push_back(rc());
`ifndef HUREADER_AUTOINC_EN
      exp_q.push_back(wc(3'd0, 8'hFF));
`endif
      exp_q.push_back(rc());
      exp_q.push_back(wc(3'd1, 8'h02));
      exp_q.push_back(wc(3'd0, 8'h00));
      exp_q.push_back(rc());
`ifndef HUREADER_AUTOINC_EN
      exp_q.push_back(wc(3'd0, 8'h01));
`endif
      exp_q.push_back(rc());
      check_bus("s2", bb);
      for (int i = 3; i <= 6; i++) exp_rx.push_back(8'h30 + 8'(i));
      check_rx("s2", rb);

      // 21-bit address wrap
      d0 = done_cnt; bb = bus_q.size(); rb = rx_q.size();
      start_cmd(21'h1FFFFF, 22'd2);
      wait_done("s3", d0, 400);
      exp_q.push_back(wc(3'd2, 8'h1F));
      exp_q.push_back(wc(3'd1, 8'hFF));
      exp_q.push_back(wc(3'd0, 8'hFF));
      exp_q.push_back(rc());
      exp_q.push_back(wc(3'd2, 8'h00));
      exp_q.push_back(wc(3'd1, 8'h00));
      exp_q.push_back(wc(3'd0, 8'h00));
      exp_q.push_back(rc());
      check_bus("s3", bb);
      exp_rx.push_back(8'h37);
      exp_rx.push_back(8'h38);
      check_rx("s3", rb);

      // consumer stalls after the first byte
      d0 = done_cnt; bb = bus_q.size(); rb = rx_q.size();
      rd_ready = 1'b0;
      start_cmd(21'h000020, 22'd2);
      n = 0;
      while (!rd_valid && n < 200) begin
         tick(1);
         n++;
      end
      check("s4 first valid", {31'h0, rd_valid}, 32'h1);
      snap = cs_total;
      tick(20);
      check("s4 cs idle during stall", cs_total - snap, 0);
      check("s4 rd_data held", {24'h0, rd_data}, 32'h39);
      check("s4 valid held", {31'h0, rd_valid}, 32'h1);
      rd_ready = 1'b1;
      wait_done("s4", d0, 300);
      exp_q.push_back(wc(3'd2, 8'h00));
      exp_q.push_back(wc(3'd1, 8'h00));
      exp_q.push_back(wc(3'd0, 8'h20));
      exp_q.push_back(rc());
`ifndef HUREADER_AUTOINC_EN
      exp_q.push_back(wc(3'd0, 8'h21));
`endif
      exp_q.push_back(rc());
      check_bus("s4", bb);
      exp_rx.push_back(8'h39);
      exp_rx.push_back(8'h3A);
      check_rx("s4", rb);

      // abort during the first read strobe
      d0 = done_cnt; bb = bus_q.size(); rb = rx_q.size();
      start_cmd(21'h000040, 22'd4);
      n = 0;
      while (prd_n && n < 300) begin
         tick(1);
         n++;
      end
      check("s5 strobe seen", {31'h0, prd_n}, 32'h0);
      tick(1);
      cmd_abort = 1'b1;
      wait_done("s5", d0, 200);
      cmd_abort = 1'b0;
      tick(10);
      check("s5 single done", done_cnt - d0, 1);
      check("s5 rd_valid", {31'h0, rd_valid}, 32'h0);
      exp_q.push_back(wc(3'd2, 8'h00));
      exp_q.push_back(wc(3'd1, 8'h00));
      exp_q.push_back(wc(3'd0, 8'h40));
      exp_q.push_back(rc());
      check_bus("s5", bb);
      check_rx("s5", rb);

      // reset in the middle of a write strobe
      start_cmd(21'h000050, 22'd1);
      n = 0;
      while (pwr_n && n < 100) begin
         tick(1);
         n++;
      end
      check("s6 write strobe seen", {31'h0, pwr_n}, 32'h0);
      #2;
      reset = 1'b1;
      #1;
      check("s6 async reset", {27'h0, pwr_n, pd_oe, busy, pexp_cs_n, prd_n}, {27'h0, 5'b10011});
      tick(1);
      reset = 1'b0;
      tick(2);

      // zero-length command
      d0 = done_cnt;
      snap = cs_total;
      start_cmd(21'h000123, 22'd0);
      check("s7 done next clock", {31'h0, done}, 32'h1);
      tick(1);
      check("s7 done single", {31'h0, done}, 32'h0);
      check("s7 busy", {31'h0, busy}, 32'h0);
      tick(5);
      check("s7 no cs", cs_total - snap, 0);
      check("s7 done count", done_cnt - d0, 1);

      check("strobe overlap", overlap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
